// File: rtl/face_core_scheduler_pkg.sv
// face_sched_pkg: shared state type and sizing helpers for the face-core scheduler
package face_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_DRAIN} state_e;
  localparam int DEF_TILE_IDX_W = 6;
  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/face_core_scheduler_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, first request at or above ptr with wrap
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[(int'(ptr_i) + i) % N]) idx_o = IW'((int'(ptr_i) + i) % N);
    any_o = |req_i;
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/face_core_scheduler.sv
// face_core_scheduler: hands frame tiles to idle detection cores round-robin and tracks completion
module face_core_scheduler import face_sched_pkg::*; #(
  parameter int N_CORES    = 4,
  parameter int TILE_IDX_W = DEF_TILE_IDX_W,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [TILE_IDX_W-1:0] num_tiles,
  input  logic [N_CORES-1:0]    core_done,
  output logic [N_CORES-1:0]    core_start,
  output logic [TILE_IDX_W-1:0] tile_id,
  output logic                  busy,
  output logic                  all_done,
  output logic [TILE_IDX_W:0]   tiles_completed,
  output logic                  timeout_err
);
  localparam int PW = $clog2(N_CORES);
  localparam int WW = wd_width(TIMEOUT);
  state_e state_q, state_d;
  logic [N_CORES-1:0] core_busy_q, core_busy_d, core_start_q, core_start_d, acc, gnt;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, gidx;
  logic [TILE_IDX_W-1:0] next_tile_q, next_tile_d, num_tiles_q, num_tiles_d, tile_id_q, tile_id_d;
  logic [TILE_IDX_W:0] done_q, done_d, ndone;
  logic [WW-1:0] wd_q, wd_d;
  logic busy_q, busy_d, all_done_q, all_done_d, err_q, err_d, gany, evt, fire, dispatch;

  rr_pick #(.N(N_CORES)) u_pick (
    .req_i(~core_busy_q), .ptr_i(rr_ptr_q), .gnt_o(gnt), .idx_o(gidx), .any_o(gany)
  );

  assign acc = core_done & core_busy_q;

  always_comb begin
    ndone = '0;
    for (int i = 0; i < N_CORES; i++) ndone = ndone + (TILE_IDX_W+1)'(acc[i]);
  end

  // selection uses registered busy, so a core freed this cycle waits one cycle for new work
  always_comb begin
    evt          = |core_start_q || |acc;
    fire         = !evt && |core_busy_q && wd_q == WW'(TIMEOUT - 1);
    dispatch     = state_q == ST_DISPATCH && next_tile_q < num_tiles_q && gany && !fire;
    state_d      = state_q;
    core_busy_d  = (core_busy_q & ~acc) | (dispatch ? gnt : '0);
    rr_ptr_d     = dispatch ? ((gidx == PW'(N_CORES - 1)) ? '0 : gidx + 1'b1) : rr_ptr_q;
    next_tile_d  = next_tile_q + TILE_IDX_W'(dispatch);
    num_tiles_d  = num_tiles_q;
    done_d       = done_q + ndone;
    wd_d         = (evt || core_busy_q == '0) ? '0 : wd_q + 1'b1;
    core_start_d = dispatch ? gnt : '0;
    tile_id_d    = dispatch ? next_tile_q : '0;
    busy_d       = busy_q;
    all_done_d   = 1'b0;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: if (go) begin
        err_d      = 1'b0;
        all_done_d = num_tiles == '0;
        if (num_tiles != '0) begin
          num_tiles_d = num_tiles;
          next_tile_d = '0;
          done_d      = '0;
          busy_d      = 1'b1;
          state_d     = ST_DISPATCH;
        end
      end
      ST_DISPATCH: if (next_tile_d == num_tiles_q) state_d = ST_DRAIN;
      ST_DRAIN: if (core_busy_q == '0 && done_q == {1'b0, num_tiles_q}) begin
        all_done_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fire) begin
      err_d       = 1'b1;
      core_busy_d = '0;
      busy_d      = 1'b0;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      core_busy_q  <= '0;
      rr_ptr_q     <= '0;
      next_tile_q  <= '0;
      num_tiles_q  <= '0;
      done_q       <= '0;
      wd_q         <= '0;
      core_start_q <= '0;
      tile_id_q    <= '0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_busy_q  <= core_busy_d;
      rr_ptr_q     <= rr_ptr_d;
      next_tile_q  <= next_tile_d;
      num_tiles_q  <= num_tiles_d;
      done_q       <= done_d;
      wd_q         <= wd_d;
      core_start_q <= core_start_d;
      tile_id_q    <= tile_id_d;
      busy_q       <= busy_d;
      all_done_q   <= all_done_d;
      err_q        <= err_d;
    end
  end

  assign core_start      = core_start_q;
  assign tile_id         = tile_id_q;
  assign busy            = busy_q;
  assign all_done        = all_done_q;
  assign tiles_completed = done_q;
  assign timeout_err     = err_q;
endmodule
